// File: rtl/digit_scan_ctrl_pkg.sv
// Purpose: shared glyph constants and scan FSM state encoding for the digit scanner.
// Latency: n/a (constants only).
// Backpressure: n/a.
package digit_scan_ctrl_pkg;

  // Active-low segment glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Purpose: display-path bundle between the scan controller and the digit mux / pins.
// Latency: n/a (wires only).
// Backpressure: none; en gates the whole scan.
interface digit_scan_ctrl_if #(
  parameter int N_DIGITS = 3
);
  logic                en;
  logic [3:0]          digit_in;
  logic [1:0]          sel;
  logic [N_DIGITS-1:0] an;
  logic [6:0]          seg;
  logic                slot_strb;

  // Controller side
  modport master (
    input  en, digit_in,
    output sel, an, seg, slot_strb
  );

  // Mux / board side
  modport slave (
    output en, digit_in,
    input  sel, an, seg, slot_strb
  );
endinterface

// File: rtl/digit_scan_ctrl_bcd_to_7seg.sv
// Purpose: BCD digit to active-low 7-segment glyph; values 10-15 show a dash.
// Latency: combinational, 0 cycles.
// Backpressure: none.
module bcd_to_7seg
  import digit_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Glyph lookup
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Purpose: multiplexed 7-seg scan (sel, anodes, segments) with a blanking gap per slot; optional LZ_SUPPRESS_EN blanks a leading zero.
// Latency: digit_in sampled on the last BLANK cycle of a slot; anode and glyph appear the next cycle.
// Backpressure: none; en=0 forces IDLE (dark, sel=0) on the next cycle.
module digit_scan_ctrl
  import digit_scan_ctrl_pkg::*;
#(
  parameter int N_DIGITS     = 3,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 8
)(
  input  logic              clk,
  input  logic              reset,
  digit_scan_ctrl_if.master bus
);

  localparam int                  CW         = $clog2(PRESCALE);
  localparam logic [CW-1:0]       CNT_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]       BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [1:0]          SEL_LAST   = 2'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF     = '1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [6:0]    glyph;
  logic [6:0]    seg_next;

  bcd_to_7seg u_dec (
    .bcd (bus.digit_in),
    .seg (glyph)
  );

  // Glyph to latch at the end of the blanking gap
  always_comb begin
    seg_next = glyph;
`ifdef LZ_SUPPRESS_EN
    if (bus.sel == SEL_LAST && bus.digit_in == 4'd0) seg_next = SEG_OFF;
`endif
  end

  // Scan FSM, slot counter and registered display outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bus.sel       <= 2'd0;
      bus.an        <= AN_OFF;
      bus.seg       <= SEG_OFF;
      bus.slot_strb <= 1'b0;
    end else begin
      bus.slot_strb <= 1'b0;
      if (!bus.en) begin
        // Going dark always restarts the scan from digit 0
        state   <= ST_IDLE;
        cnt     <= '0;
        bus.sel <= 2'd0;
        bus.an  <= AN_OFF;
        bus.seg <= SEG_OFF;
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_BLANK;
            cnt     <= '0;
            bus.sel <= 2'd0;
            bus.an  <= AN_OFF;
          end
          ST_BLANK: begin
            cnt    <= cnt + 1'b1;
            bus.an <= AN_OFF;
            if (cnt == BLANK_LAST) begin
              // Mux output has settled: capture glyph and light this digit
              bus.seg <= seg_next;
              bus.an  <= AN_OFF & ~(N_DIGITS'(1) << bus.sel);
              state   <= ST_SHOW;
            end
          end
          ST_SHOW: begin
            if (cnt == CNT_LAST) begin
              cnt           <= '0;
              bus.sel       <= (bus.sel == SEL_LAST) ? 2'd0 : bus.sel + 2'd1;
              bus.slot_strb <= 1'b1;
              bus.an        <= AN_OFF;
              state         <= ST_BLANK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state  <= ST_IDLE;
            cnt    <= '0;
            bus.an <= AN_OFF;
          end
        endcase
      end
    end
  end

endmodule
